hazard_ctrl: RTL and testbench

Pipeline hazard controller for the RV32I core. It watches the decode and execute stages and generates the hold, bubble and flush controls for fetch and `instr_decode`. Three hazards are sequenced through a Moore state machine:
- load-use stalls;
- branch/jump redirect flushes;
- memory-busy waits.

It also keeps a saturating count of lost cycles for performance debug.

---
 rtl/hazard_ctrl.sv | 97 +++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: sequences load-use stalls, redirect flushes and
// memory-busy waits through a Moore FSM, and counts lost cycles for debug.
module hazard_ctrl #(
    parameter int          XLEN         = 32,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [6:0]  LOAD_OPCODE  = 7'b0000011
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            id_rs_read_en_i,
    input  logic [6:0]      ex_opcode_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            mem_busy_i,
    output logic            pc_hold_o,
    output logic            halt_o,
    output logic            flush_o,
    output logic            pc_load_o,
    output logic [XLEN-1:0] pc_load_val_o,
    output logic [1:0]      state_o,
    output logic [15:0]     stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, next_state;
    logic [3:0] flush_cnt, next_cnt;
    logic       load_use;

    assign load_use = (ex_opcode_i == LOAD_OPCODE) && (ex_rd_addr_i != 5'd0) &&
                      id_rs_read_en_i &&
                      ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        next_state = state;
        next_cnt   = flush_cnt;
        if (redirect_i) begin
            next_state = FLUSH;
            next_cnt   = FLUSH_LOAD;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy_i)    next_state = MEM_WAIT;
                    else if (load_use) next_state = LOAD_STALL;
                end
                LOAD_STALL: next_state = mem_busy_i ? MEM_WAIT : RUN;
                FLUSH: begin
                    // Memory busy only matters once the wrong-path squash is done.
                    if (flush_cnt != 4'd0) next_cnt   = flush_cnt - 4'd1;
                    else                   next_state = mem_busy_i ? MEM_WAIT : RUN;
                end
                MEM_WAIT: if (!mem_busy_i) next_state = RUN;
                default:  next_state = RUN;
            endcase
        end
    end

    // Control outputs are registered from the next state, so they always match state_o.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= RUN;
            flush_cnt     <= 4'd0;
            pc_hold_o     <= 1'b0;
            halt_o        <= 1'b0;
            flush_o       <= 1'b0;
            pc_load_o     <= 1'b0;
            pc_load_val_o <= '0;
            stall_cnt_o   <= 16'd0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state     <= next_state;
            flush_cnt <= next_cnt;
            pc_hold_o <= (next_state == LOAD_STALL) || (next_state == MEM_WAIT);
            halt_o    <= (next_state != RUN);
            flush_o   <= (next_state == FLUSH);
            pc_load_o <= redirect_i;
            if (redirect_i)
                pc_load_val_o <= redirect_pc_i;
            if ((state != RUN) && (stall_cnt_o != 16'hFFFF))
                stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [4:0]  id_rs1_addr_i = 5'd0;
    logic [4:0]  id_rs2_addr_i = 5'd0;
    logic        id_rs_read_en_i = 1'b0;
    logic [6:0]  ex_opcode_i = 7'd0;
    logic [4:0]  ex_rd_addr_i = 5'd0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        mem_busy_i = 1'b0;
    logic        pc_hold_o, halt_o, flush_o, pc_load_o;
    logic [31:0] pc_load_val_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .LOAD_OPCODE(7'b0000011)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_rs_read_en_i (id_rs_read_en_i),
        .ex_opcode_i     (ex_opcode_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_busy_i      (mem_busy_i),
        .pc_hold_o       (pc_hold_o),
        .halt_o          (halt_o),
        .flush_o         (flush_o),
        .pc_load_o       (pc_load_o),
        .pc_load_val_o   (pc_load_val_o),
        .state_o         (state_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare the full control word: state, pc_hold, halt, flush, pc_load.
    task automatic check_ctrl(input string tag, input logic [1:0] st, input logic hold,
                              input logic hlt, input logic fl, input logic ld);
        check(tag, {27'd0, state_o, pc_hold_o, halt_o, flush_o, pc_load_o},
                   {27'd0, st, hold, hlt, fl, ld});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic en, input logic [4:0] rd);
        ex_opcode_i     = en ? 7'h03 : 7'h33;
        ex_rd_addr_i    = rd;
        id_rs2_addr_i   = rd;
        id_rs_read_en_i = en;
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 reset_i = 1'b1;
        #1;
        check_ctrl("reset_ctrl", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_val", pc_load_val_o, 32'd0);
        check("reset_cnt", {16'd0, stall_cnt_o}, 32'd0);
        tick();
        @(negedge clk) reset_i = 1'b0;
        tick();
        check_ctrl("idle_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use on rs2 -> exactly one stall cycle
        set_load_use(1'b1, 5'd5);
        tick();
        check_ctrl("lu_stall", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        set_load_use(1'b0, 5'd0);
        tick();
        check_ctrl("lu_back_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_cnt", {16'd0, stall_cnt_o}, 32'd1);

        // Load to x0 never stalls
        set_load_use(1'b1, 5'd0);
        tick();
        check_ctrl("lu_rd0", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_load_use(1'b0, 5'd0);

        // Redirect -> two flush cycles, pc_load only in the first
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        check_ctrl("rd_f1", 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        check("rd_val", pc_load_val_o, 32'h100);
        redirect_i = 1'b0; redirect_pc_i = 32'hDEAD;
        tick();
        check_ctrl("rd_f2", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_ctrl("rd_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rd_val_hold", pc_load_val_o, 32'h100);

        // Second redirect in the last flush cycle restarts the flush
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        tick();
        check_ctrl("rr_f2", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        check_ctrl("rr_restart", 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        check("rr_val", pc_load_val_o, 32'h200);
        redirect_i = 1'b0;
        tick();
        check_ctrl("rr_f2b", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_ctrl("rr_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rr_cnt", {16'd0, stall_cnt_o}, 32'd7);

        // mem_busy for 4 samples -> 4 MEM_WAIT cycles
        mem_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_ctrl("mw_wait", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        mem_busy_i = 1'b0;
        tick();
        check_ctrl("mw_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mw_cnt", {16'd0, stall_cnt_o}, 32'd11);

        // mem_busy during flush is deferred to after the last flush cycle
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        tick();
        redirect_i = 1'b0; mem_busy_i = 1'b1;
        tick();
        check_ctrl("fb_f2", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_ctrl("fb_wait", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_busy_i = 1'b0;
        tick();
        check_ctrl("fb_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Priority: redirect beats mem_busy and load_use
        redirect_i = 1'b1; redirect_pc_i = 32'h400; mem_busy_i = 1'b1;
        set_load_use(1'b1, 5'd7);
        tick();
        check_ctrl("pri_flush", 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        check("pri_val", pc_load_val_o, 32'h400);
        redirect_i = 1'b0; mem_busy_i = 1'b0;
        set_load_use(1'b0, 5'd0);
        tick();
        tick();
        check_ctrl("pri_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // mem_busy beats load_use; the held hazard re-detects after the wait
        mem_busy_i = 1'b1;
        set_load_use(1'b1, 5'd9);
        tick();
        check_ctrl("ml_wait", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_busy_i = 1'b0;
        tick();
        check_ctrl("ml_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctrl("ml_stall", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        set_load_use(1'b0, 5'd0);
        tick();
        check_ctrl("ml_run2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ml_cnt", {16'd0, stall_cnt_o}, 32'd18);

        // mem_busy during the load stall goes to MEM_WAIT
        set_load_use(1'b1, 5'd3);
        tick();
        set_load_use(1'b0, 5'd0); mem_busy_i = 1'b1;
        tick();
        check_ctrl("ls_wait", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_busy_i = 1'b0;
        tick();
        check_ctrl("ls_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ls_cnt", {16'd0, stall_cnt_o}, 32'd20);

        // Reset mid-operation returns everything to idle without an edge
        mem_busy_i = 1'b1;
        tick();
        #2 reset_i = 1'b1;
        #1;
        check_ctrl("mid_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_reset_cnt", {16'd0, stall_cnt_o}, 32'd0);
        check("mid_reset_val", pc_load_val_o, 32'd0);
        @(negedge clk) reset_i = 1'b0;

        // Counter saturation
        repeat (70000) tick();
        check("sat_cnt", {16'd0, stall_cnt_o}, 32'h0000FFFF);
        check_ctrl("sat_wait", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_busy_i = 1'b0;
        tick();
        tick();
        check_ctrl("sat_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_hold", {16'd0, stall_cnt_o}, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
